// File: rtl/div_unit_if.sv
// div_unit_if: operand/launch inputs and register-file writeback outputs of the divide unit
interface div_unit_if #(
  parameter int W      = 32,
  parameter int nu_reg = 5
);
  logic              start_i;
  logic [1:0]        op_i;
  logic [W-1:0]      rs1_data_i;
  logic [W-1:0]      rs2_data_i;
  logic [nu_reg-1:0] rd_addr_i;
  logic              flush_i;
  logic              busy_o;
  logic              wb_en_o;
  logic [nu_reg-1:0] wb_addr_o;
  logic [W-1:0]      wb_data_o;
  modport master (
    output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  busy_o, wb_en_o, wb_addr_o, wb_data_o
  );
  modport slave (
    input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output busy_o, wb_en_o, wb_addr_o, wb_data_o
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle
module div_unit #(
  parameter int W      = 32,
  parameter int nu_reg = 5
) (
  input logic      clk_i,
  input logic      rst_ni,
  div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  state_e            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [1:0]        op_q;
  logic [nu_reg-1:0] rd_q;
  logic              neg_q, sgn_q;
  logic [W-1:0]      dvd_q, dvs_q, rem_q, res_q;
  logic              signed_op, s1, s2, div0, ovf, ge, launch;
  logic [W:0]        sh;
  logic [W-1:0]      rem_n, quo_n, quo_f, rem_f;
  assign signed_op = ~bus.op_i[0];
  assign s1        = signed_op & bus.rs1_data_i[W-1];
  assign s2        = signed_op & bus.rs2_data_i[W-1];
  assign div0      = bus.rs2_data_i == '0;
  assign ovf       = signed_op && bus.rs1_data_i == {1'b1, {(W-1){1'b0}}} && bus.rs2_data_i == '1;
  assign launch    = state_q == IDLE && bus.start_i && !bus.flush_i;
  // dvd_q shifts out dividend bits on the left while quotient bits enter on the right
  assign sh    = {rem_q, dvd_q[W-1]};
  assign ge    = sh >= {1'b0, dvs_q};
  assign rem_n = ge ? sh[W-1:0] - dvs_q : sh[W-1:0];
  assign quo_n = {dvd_q[W-2:0], ge};
  assign quo_f = (neg_q && op_q == 2'b00) ? -quo_n : quo_n;
  assign rem_f = (sgn_q && op_q == 2'b10) ? -rem_n : rem_n;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (bus.flush_i) state_d = IDLE;
    else if (state_q == IDLE && bus.start_i) state_d = (div0 || ovf) ? DONE : CALC;
    else if (state_q == CALC && cnt_q == 5'd31) state_d = DONE;
    else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      neg_q <= 1'b0;
      sgn_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      res_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
      op_q  <= bus.op_i;
      rd_q  <= bus.rd_addr_i;
      neg_q <= s1 ^ s2;
      sgn_q <= s1;
      dvd_q <= s1 ? -bus.rs1_data_i : bus.rs1_data_i;
      dvs_q <= s2 ? -bus.rs2_data_i : bus.rs2_data_i;
      rem_q <= '0;
      if (div0)     res_q <= bus.op_i[1] ? bus.rs1_data_i : '1;
      else if (ovf) res_q <= bus.op_i[1] ? '0 : bus.rs1_data_i;
    end else if (state_q == CALC && !bus.flush_i) begin
      cnt_q <= cnt_q + 5'd1;
      rem_q <= rem_n;
      dvd_q <= quo_n;
      if (cnt_q == 5'd31) res_q <= op_q[1] ? rem_f : quo_f;
    end
  end
  assign bus.busy_o    = state_q != IDLE;
  assign bus.wb_en_o   = state_q == DONE && |rd_q && !bus.flush_i;
  assign bus.wb_addr_o = rd_q;
  assign bus.wb_data_o = res_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expected writes queued at issue, popped by a writeback monitor
module tb_div_unit;
  logic clk_i = 1'b0;
  logic rst_ni;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  div_unit_if #(.W(32), .nu_reg(5)) bus ();
  div_unit #(.W(32), .nu_reg(5)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? a % b : a / b;
    return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
  endfunction
  function automatic bit special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction
  // writeback monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk_i) begin
    if (rst_ni && bus.wb_en_o) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb: got addr %0d data %h expected no write", bus.wb_addr_o, bus.wb_data_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wb_addr", 32'(bus.wb_addr_o), 32'(e.addr));
        check("wb_data", bus.wb_data_o, e.data);
        check("wb_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end
  task automatic wait_idle();
    int n = 0;
    while (bus.busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_idle", 32'(bus.busy_o), 32'd0);
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit expect_wb);
    wait_idle();
    bus.op_i       = op;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.rd_addr_i  = rd;
    bus.start_i    = 1'b1;
    if (expect_wb && rd != 0)
      q.push_back('{addr: rd, data: model(op, a, b), cyc: cyc + (special(op, a, b) ? 1 : 33)});
    @(negedge clk_i);
    bus.start_i = 1'b0;
  endtask
  initial begin
    int n;
    rst_ni         = 1'b0;
    bus.start_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.op_i       = '0;
    bus.rs1_data_i = '0;
    bus.rs2_data_i = '0;
    bus.rd_addr_i  = '0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_wb_en", 32'(bus.wb_en_o), 32'd0);
    check("rst_wb_addr", 32'(bus.wb_addr_o), 32'd0);
    check("rst_wb_data", bus.wb_data_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    issue(2'b01, 32'd100, 32'd7, 5'd5, 1);
    issue(2'b11, 32'd100, 32'd7, 5'd5, 1);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd7, 1);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, 1);
    issue(2'b01, 32'd1234, 32'd0, 5'd9, 1);
    issue(2'b10, 32'd1234, 32'd0, 5'd10, 1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);
    // flush during the tenth iteration, then restart at once
    issue(2'b01, 32'd1000, 32'd3, 5'd3, 0);
    repeat (9) @(negedge clk_i);
    bus.flush_i = 1'b1;
    @(negedge clk_i);
    bus.flush_i = 1'b0;
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    issue(2'b01, 32'd1000, 32'd3, 5'd3, 1);
    // flush held across the DONE cycle
    issue(2'b01, 32'd50, 32'd5, 5'd4, 0);
    repeat (31) @(negedge clk_i);
    @(posedge clk_i);
    #1 bus.flush_i = 1'b1;
    #3;
    check("done_flush_wb_en", 32'(bus.wb_en_o), 32'd0);
    check("done_flush_busy", 32'(bus.busy_o), 32'd1);
    @(posedge clk_i);
    #1 bus.flush_i = 1'b0;
    check("done_flush_idle", 32'(bus.busy_o), 32'd0);
    // asynchronous reset mid-CALC
    issue(2'b01, 32'd999, 32'd4, 5'd4, 0);
    repeat (15) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_wb_en", 32'(bus.wb_en_o), 32'd0);
    check("midrst_wb_addr", 32'(bus.wb_addr_o), 32'd0);
    check("midrst_wb_data", bus.wb_data_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    // start while busy must be ignored
    issue(2'b01, 32'd5000, 32'd7, 5'd13, 1);
    repeat (5) @(negedge clk_i);
    bus.op_i       = 2'b00;
    bus.rs1_data_i = 32'd77;
    bus.rs2_data_i = 32'd7;
    bus.rd_addr_i  = 5'd14;
    bus.start_i    = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    // rd = 0: full busy window, never a write
    wait_idle();
    issue(2'b01, 32'd100, 32'd7, 5'd0, 1);
    n = 0;
    while (bus.busy_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    check("rd0_busy_cycles", 32'(n), 32'd33);
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = 32'h0;
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 9));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (i % 10 == 0) a = 32'h8000_0000;
      if (i % 10 == 5) b = 32'hFFFF_FFFF;
      issue(op, a, b, 5'($urandom_range(1, 31)), 1);
    end
    wait_idle();
    repeat (3) @(negedge clk_i);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle RV32M divide/remainder unit sitting between the register file's read ports and its write port. It takes both operand values read from the register file plus the destination register index, computes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm (one quotient bit per cycle), and returns the result through a single-cycle write strobe. The write strobe, address and data connect directly to the register file write port.

## Interface

Parameters:
- W, 32, operand/result width
- nu_reg, 5, register index width

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- start_i  input  1  launch operation; accepted only in IDLE
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start_i
- rs1_data_i  input  W  dividend; sampled with start_i
- rs2_data_i  input  W  divisor; sampled with start_i
- rd_addr_i  input  nu_reg  destination index; sampled with start_i
- flush_i  input  1  abort any in-flight operation
- busy_o  output  1  high in CALC and DONE
- wb_en_o  output  1  register-file write enable, one-cycle pulse
- wb_addr_o  output  nu_reg  destination index of the completed operation
- wb_data_o  output  W  quotient or remainder

## Operation

- FSM states: IDLE, CALC, DONE.
- IDLE with start_i=1 and flush_i=0:
  - Latch op, rd, and the operand sign flags.
  - For signed ops, latch operand magnitudes; otherwise latch raw operands.
  - Clear the partial remainder and set the iteration counter (5-bit) to 0.
  - Divisor == 0 → DONE directly. Quotient = all ones; remainder = dividend (raw rs1).
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF → DONE directly. Quotient = 0x80000000; remainder = 0.
  - Otherwise → CALC.
- CALC, each cycle:
  - Shift {rem, dividend} left by 1.
  - If the shifted rem ≥ divisor (W+1-bit unsigned compare), subtract and set quotient bit = 1; otherwise quotient bit = 0.
  - Increment the counter.
  - After the 32nd iteration (counter == 31 at the edge) → DONE.
  - On that same edge, apply sign correction:
    - Quotient is negated when the operand signs differ (DIV only).
    - Remainder takes the dividend's sign (REM only).
  - All arithmetic is two's complement, W bits, and wraps.
- DONE: the result register holds the quotient (op 00/01) or the remainder (op 10/11).
  - wb_en_o = 1 for exactly this one cycle, unless the latched rd == 0, in which case wb_en_o stays 0.
  - Next edge → IDLE.
- start_i while busy_o=1 is ignored; no queuing.
- flush_i=1 in any state → IDLE at the next edge.
  - No wb_en_o pulse for the aborted operation.
  - flush_i beats start_i when both are high in the same cycle.
  - A flush coinciding with DONE suppresses that cycle's wb_en_o combinationally.
- wb_addr_o and wb_data_o hold their last values outside DONE; they are only meaningful while wb_en_o=1.

## Timing

- Reset (asynchronous, rst_ni=0):
  - State = IDLE.
  - busy_o = 0, wb_en_o = 0, wb_addr_o = 0, wb_data_o = 0.
  - Counter and datapath registers = 0.
- Reset asserted mid-operation: the operation is aborted immediately and no write is produced.
- Start accepted at edge E0; busy_o is high from the cycle after E0.
- Normal path:
  - Iterations occur at E1..E32; DONE is entered at E32.
  - wb_en_o is high for the cycle between E32 and E33; the register file captures at E33.
  - busy_o falls after E33, so a new start can be accepted at E33.
  - Latency is 33 cycles start-to-write.
- Special cases (divide by zero, overflow):
  - DONE is entered at E0 and the register file captures at E1.
  - Latency is 1 cycle.
- Back-to-back normal operations: one result every 33 cycles.

## Test plan

- DIVU 100/7 rd=5 → single wb_en_o pulse 33 cycles after start, wb_addr_o=5, wb_data_o=14. REMU with the same operands → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3). REM with the same operands → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- Divide by zero: DIVU 1234/0 → 0xFFFFFFFF; REM 1234/0 → 1234. Each write is captured one edge after start.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Latency 1.
- Flush:
  - flush_i at iteration 10 → no wb_en_o, busy_o=0 the next cycle, and a new start is accepted immediately.
  - flush_i held during DONE → no pulse.
  - rst_ni pulsed mid-CALC → all outputs 0.
- Start pulsed while busy → ignored, and the first result is unchanged.
- rd=0 → busy_o for 33 cycles, wb_en_o never asserted.
